operand_fetch: RTL and testbench
================================

# operand_fetch

Decode/operand-fetch stage directly upstream of the 3-bit-op ALU. Holds the 32x32 architectural register file, decodes a MIPS-subset instruction into ALU op and operands, and presents them through a single-entry registered output with valid/ready handshake. Accepts write-back from the end of the pipe and supports flush on branch redirect.

## Interface
Parameters: none.
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `instr` valid
- `in_ready`  out  1  stage can accept `instr` this cycle
- `instr`  in  32  instruction word
- `wb_en`  in  1  register write-back enable
- `wb_addr`  in  5  write-back register index
- `wb_data`  in  32  write-back data
- `flush`  in  1  discard held entry and block input this cycle
- `out_valid`  out  1  output entry valid
- `out_ready`  in  1  downstream consumes entry
- `alu_a`, `alu_b`  out  32  ALU operands
- `alu_op`  out  3  ALU op (0 add, 1 noop, 2 and, 3 or, 4 slt, 5 sll-by-1, 6 beq, 7 bne)
- `out_imm`  out  32  sign-extended imm[15:0]
- `out_rd`  out  5  destination register
- `out_wb_en`  out  1  instruction writes `out_rd`
- `out_is_branch`  out  1  beq/bne
- `out_illegal`  out  1  unsupported encoding

One clock; reset is synchronous and active-high.

## Operation
- Register file: 32 x 32 bits; r0 reads 0; writes to r0 ignored; write at edge when `wb_en`.
- Reads: rs = instr[25:21], rt = instr[20:16], combinational from array (bypass see Configuration).
- Decode (op = instr[31:26], funct = instr[5:0]):
  - op 0x00, funct 0x20/0x24/0x25/0x2A: alu_op 0/2/3/4; a=R[rs], b=R[rt], rd=instr[15:11], wb_en=1.
  - op 0x00, funct 0x00, shamt==1: alu_op 5; a=R[rt], b=0, rd=instr[15:11], wb_en=1.
  - instr==0x00000000: alu_op 1, a=b=0, wb_en=0, not illegal.
  - op 0x08 (addi): alu_op 0; a=R[rs], b=out_imm, rd=rt, wb_en=1.
  - op 0x04/0x05: alu_op 6/7; a=R[rs], b=R[rt], rd=0, wb_en=0, is_branch=1.
  - all else: alu_op 1, a=b=0, rd=0, wb_en=0, illegal=1.
  - wb_en forced 0 when decoded rd==0.
- States EMPTY (out_valid=0) / FULL (out_valid=1).
- `in_ready = !flush && (!out_valid || out_ready)`.
- Accept (in_valid && in_ready): capture all outputs, go FULL.
- FULL && out_ready && no accept: go EMPTY.
- FULL && !out_ready: all outputs held bit-stable.
- flush: go EMPTY next cycle; no accept; write-back still performed.
- Captured operands are not updated by later write-backs; hazards are resolved upstream.

## Timing
- Latency: accept at edge N -> entry visible on outputs after edge N; consumable in cycle N+1.
- Throughput 1/cycle with `out_ready` held high.
- Reset: out_valid=0, all data outputs 0, all 32 registers 0; `wb_en`/`in_valid` ignored during `rst`.
- Reset mid-operation: held entry discarded, register contents lost.
- rst > flush > accept priority.
- Write-back and read of same register in same cycle: see Configuration.

## Configuration
- `OPERAND_FETCH_WB_BYPASS_EN` defined: if `wb_en && wb_addr!=0 && wb_addr==rs/rt`, that operand takes `wb_data` in the same cycle.
- Undefined: operand takes the pre-write array value; write visible from next cycle.

## Test plan
- Reset, write r1=5, r2=7; accept 0x00221820 (add r3,r1,r2) -> next cycle out_valid=1, a=5, b=7, op=0, rd=3, wb_en=1.
- Accept 0x2024FFFF (addi r4,r1,-1) -> a=5, b=0xFFFFFFFF, out_imm=0xFFFFFFFF, op=0, rd=4.
- out_ready=0, two back-to-back instrs -> first held stable, in_ready=0; second accepted cycle after out_ready=1; no loss or duplication.
- wb r5=0x1234 same cycle as reading r5 -> a=0x1234 with macro, a=0 without; next instr reads 0x1234 either way.
- Write r0=0xFFFF, read r0 -> 0; instr 0xFC000000 -> op=1, illegal=1, wb_en=0; 0x10220000 -> op=6, is_branch=1, wb_en=0.
- flush while FULL -> out_valid=0 next cycle, in_ready=0 during flush; rst while FULL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: 32x32 register file, MIPS-subset decode, single-entry valid/ready output.
// Optional same-cycle write-back bypass on operand reads: define OPERAND_FETCH_WB_BYPASS_EN.
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_is_branch,
    output logic        out_illegal
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state, state_nxt;
    logic [31:0] regs [32];
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, shamt;
    logic [31:0] rs_val, rt_val;
    logic        accept;

    logic [2:0]  d_op;
    logic [31:0] d_a, d_b, d_imm;
    logic [4:0]  d_rd;
    logic        d_wb, d_br, d_ill;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];

    always_comb begin
        rs_val = (rs == '0) ? '0 : regs[rs];
        rt_val = (rt == '0) ? '0 : regs[rt];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_en && wb_addr != '0 && wb_addr == rs) rs_val = wb_data;
        if (wb_en && wb_addr != '0 && wb_addr == rt) rt_val = wb_data;
`endif
    end

    always_comb begin
        d_op  = 3'd1;
        d_a   = '0;
        d_b   = '0;
        d_rd  = '0;
        d_wb  = 1'b0;
        d_br  = 1'b0;
        d_ill = 1'b1;
        d_imm = {{16{instr[15]}}, instr[15:0]};
        if (instr == '0) begin
            d_ill = 1'b0;
        end else begin
            case (opcode)
                6'h00: begin
                    case (funct)
                        6'h20, 6'h24, 6'h25, 6'h2A: begin
                            d_ill = 1'b0;
                            d_a   = rs_val;
                            d_b   = rt_val;
                            d_rd  = instr[15:11];
                            d_wb  = 1'b1;
                            case (funct)
                                6'h20:   d_op = 3'd0;
                                6'h24:   d_op = 3'd2;
                                6'h25:   d_op = 3'd3;
                                default: d_op = 3'd4;
                            endcase
                        end
                        6'h00: begin
                            if (shamt == 5'd1) begin
                                d_ill = 1'b0;
                                d_op  = 3'd5;
                                d_a   = rt_val;
                                d_rd  = instr[15:11];
                                d_wb  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                6'h08: begin
                    d_ill = 1'b0;
                    d_op  = 3'd0;
                    d_a   = rs_val;
                    d_b   = d_imm;
                    d_rd  = rt;
                    d_wb  = 1'b1;
                end
                6'h04, 6'h05: begin
                    d_ill = 1'b0;
                    d_op  = (opcode == 6'h04) ? 3'd6 : 3'd7;
                    d_a   = rs_val;
                    d_b   = rt_val;
                    d_br  = 1'b1;
                end
                default: ;
            endcase
        end
        // Writes to r0 are architecturally dropped, so never advertise them.
        if (d_rd == '0) d_wb = 1'b0;
    end

    assign out_valid = (state == FULL);
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = FULL;
        else if (state == FULL && out_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            out_imm       <= '0;
            out_rd        <= '0;
            out_wb_en     <= 1'b0;
            out_is_branch <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (accept) begin
            alu_a         <= d_a;
            alu_b         <= d_b;
            alu_op        <= d_op;
            out_imm       <= d_imm;
            out_rd        <= d_rd;
            out_wb_en     <= d_wb;
            out_is_branch <= d_br;
            out_illegal   <= d_ill;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed steps from the test plan, then random traffic
// compared cycle by cycle against a spec-level model (register array + single expected entry).
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
    logic [31:0] instr, wb_data, alu_a, alu_b, out_imm;
    logic [4:0]  wb_addr, out_rd;
    logic [2:0]  alu_op;
    logic        out_wb_en, out_is_branch, out_illegal;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .out_imm(out_imm), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .out_is_branch(out_is_branch), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] a, b, imm;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        wb, br, ill;
    } ent_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] mreg [32];
    ent_t        exp_e;
    logic        mvalid = 1'b0;
    logic        mzero  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (we && wa != 0 && wa == a) return wd;
`endif
        return mreg[a];
    endfunction

    function automatic ent_t decode(input logic [31:0] i, input logic [31:0] ra, input logic [31:0] rb);
        ent_t e;
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        e = '0;
        e.op  = 3'd1;
        e.ill = 1'b1;
        e.imm = {{16{i[15]}}, i[15:0]};
        if (i == 0) begin
            e.ill = 1'b0;
        end else if (op == 0 && (fn == 6'h20 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
            e.op  = (fn == 6'h20) ? 3'd0 : (fn == 6'h24) ? 3'd2 : (fn == 6'h25) ? 3'd3 : 3'd4;
            e.a = ra; e.b = rb; e.rd = i[15:11]; e.wb = 1'b1; e.ill = 1'b0;
        end else if (op == 0 && fn == 0 && i[10:6] == 5'd1) begin
            e.op = 3'd5; e.a = rb; e.rd = i[15:11]; e.wb = 1'b1; e.ill = 1'b0;
        end else if (op == 6'h08) begin
            e.op = 3'd0; e.a = ra; e.b = e.imm; e.rd = i[20:16]; e.wb = 1'b1; e.ill = 1'b0;
        end else if (op == 6'h04 || op == 6'h05) begin
            e.op = (op == 6'h04) ? 3'd6 : 3'd7; e.a = ra; e.b = rb; e.br = 1'b1; e.ill = 1'b0;
        end
        if (e.rd == 0) e.wb = 1'b0;
        return e;
    endfunction

    // One clock: drive inputs, check in_ready, advance the model, check outputs after the edge.
    task automatic cycle(input logic r, input logic v, input logic [31:0] ins, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic fl, input logic ordy);
        logic mready, acc;
        logic [31:0] ra, rb;
        rst = r; in_valid = v; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd;
        flush = fl; out_ready = ordy;
        #3;
        mready = !fl && (!mvalid || ordy);
        if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, mready});
        acc = v && mready;
        ra = rd_reg(ins[25:21], we, wa, wd);
        rb = rd_reg(ins[20:16], we, wa, wd);
        if (r) begin
            for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
            mvalid = 1'b0;
            exp_e  = '0;
            mzero  = 1'b1;
        end else begin
            if (fl) mvalid = 1'b0;
            else if (acc) begin
                exp_e  = decode(ins, ra, rb);
                mvalid = 1'b1;
                mzero  = 1'b0;
            end else if (mvalid && ordy) mvalid = 1'b0;
            if (we && wa != 0) mreg[wa] = wd;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, mvalid});
        if (mvalid || mzero) begin
            chk("alu_a", alu_a, exp_e.a);
            chk("alu_b", alu_b, exp_e.b);
            chk("alu_op", {29'd0, alu_op}, {29'd0, exp_e.op});
            chk("out_imm", out_imm, exp_e.imm);
            chk("out_rd", {27'd0, out_rd}, {27'd0, exp_e.rd});
            chk("out_wb_en", {31'd0, out_wb_en}, {31'd0, exp_e.wb});
            chk("out_is_branch", {31'd0, out_is_branch}, {31'd0, exp_e.br});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, exp_e.ill});
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] s, t, d;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0: return {6'h00, s, t, d, 5'd0, 6'h20};
            1: return {6'h00, s, t, d, 5'd0, 6'h24};
            2: return {6'h00, s, t, d, 5'd0, 6'h25};
            3: return {6'h00, s, t, d, 5'd0, 6'h2A};
            4: return {6'h00, 5'd0, t, d, 5'($urandom_range(0, 2)), 6'h00};
            5: return 32'd0;
            6: return {6'h08, s, t, 16'($urandom)};
            7: return {($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, s, t, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 1, 5'd1, 32'd5, 0, 1);
        cycle(0, 0, 0, 1, 5'd2, 32'd7, 0, 1);

        cycle(0, 1, 32'h00221820, 0, 0, 0, 0, 1);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_a", alu_a, 32'd5);
        chk("add_b", alu_b, 32'd7);
        chk("add_op", {29'd0, alu_op}, 32'd0);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_wb", {31'd0, out_wb_en}, 32'd1);

        cycle(0, 1, 32'h2024FFFF, 0, 0, 0, 0, 1);
        chk("addi_a", alu_a, 32'd5);
        chk("addi_b", alu_b, 32'hFFFFFFFF);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd", {27'd0, out_rd}, 32'd4);

        // Backpressure: first entry held, second waits, then accepted exactly once.
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 32'h00221824, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            cycle(0, 1, 32'h00221825, 0, 0, 0, 0, 0);
            chk("hold_op", {29'd0, alu_op}, 32'd2);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(0, 1, 32'h00221825, 0, 0, 0, 0, 1);
        chk("second_op", {29'd0, alu_op}, 32'd3);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // Same-cycle write-back and read of r5.
        cycle(0, 1, 32'h20A60000, 1, 5'd5, 32'h1234, 0, 1);
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        chk("bypass_a", alu_a, 32'h1234);
`else
        chk("nobypass_a", alu_a, 32'd0);
`endif
        cycle(0, 1, 32'h20A60000, 0, 0, 0, 0, 1);
        chk("after_wb_a", alu_a, 32'h1234);

        cycle(0, 1, 32'h00003820, 1, 5'd0, 32'hFFFF, 0, 1);
        cycle(0, 1, 32'h00003820, 0, 0, 0, 0, 1);
        chk("r0_a", alu_a, 32'd0);
        cycle(0, 1, 32'hFC000000, 0, 0, 0, 0, 1);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_op", {29'd0, alu_op}, 32'd1);
        cycle(0, 1, 32'h10220000, 0, 0, 0, 0, 1);
        chk("beq_op", {29'd0, alu_op}, 32'd6);
        chk("beq_br", {31'd0, out_is_branch}, 32'd1);
        chk("beq_wb", {31'd0, out_wb_en}, 32'd0);

        cycle(0, 1, 32'h00221820, 0, 0, 0, 1, 0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        cycle(0, 1, 32'h00221820, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'h00221820, 1, 5'd3, 32'd9, 0, 0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
